// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the fifo_sync write-port arbiter: FSM state codes and
// the round-robin winner search used by rr_picker.
package fifo_arb_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // Upper bound on requesters handled by next_rr; request vectors are zero-extended to it.
   localparam int unsigned RR_MAX_REQ = 32;

   // First valid index strictly after grant_id, wrapping modulo num_req; falls back
   // to grant_id when nothing is valid (callers qualify with |req_valid).
   function automatic int unsigned next_rr(
      input int unsigned               grant_id,
      input logic [RR_MAX_REQ-1:0]     req_valid,
      input int unsigned               num_req
   );
      int unsigned idx;
      int unsigned win;
      logic        found;
      win   = grant_id;
      found = 1'b0;
      for (int unsigned k = 1; k <= num_req; k++) begin
         idx = (grant_id + k) % num_req;
         if (!found && req_valid[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search: the winner is the first valid requester
// after the most recent grantee, wrapping at NUM_REQ.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  i_req_valid,
   input  logic [ID_WIDTH-1:0] i_grant_id,
   output logic [ID_WIDTH-1:0] o_win_id,
   output logic                o_win_valid
);

   logic [RR_MAX_REQ-1:0] w_req_ext;

   assign w_req_ext   = RR_MAX_REQ'(i_req_valid);
   assign o_win_id    = ID_WIDTH'(next_rr(32'(i_grant_id), w_req_ext, NUM_REQ));
   assign o_win_valid = |i_req_valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one fifo_sync write port among
// NUM_REQ requesters; never writes while the FIFO reports full.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 8,
   parameter int ID_WIDTH   = $clog2(NUM_REQ),
   parameter int CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_enable,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ-1:0]            i_req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]            o_req_ready,
   output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
   output logic                          o_fifo_wr_en,
   input  logic                          i_fifo_full,
   output logic                          o_grant_valid,
   output logic [ID_WIDTH-1:0]           o_grant_id,
   output logic [CNT_WIDTH-1:0]          o_beat_cnt
);

   logic [0:0]           r_state;
   logic [ID_WIDTH-1:0]  r_grant_id;
   logic [CNT_WIDTH-1:0] r_beat_cnt;

   logic [ID_WIDTH-1:0]   w_win_id;
   logic                  w_win_valid;
   logic                  w_in_grant;
   logic                  w_accept_ok;
   logic                  w_sel_valid;
   logic                  w_sel_last;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic                  w_burst_end;
   logic                  w_release;

   rr_picker #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_rr_picker (
      .i_req_valid (i_req_valid),
      .i_grant_id  (r_grant_id),
      .o_win_id    (w_win_id),
      .o_win_valid (w_win_valid)
   );

   // Select the grantee's lane; indices >= NUM_REQ never match and yield zeros.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_last  = 1'b0;
      w_sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant_id == ID_WIDTH'(i)) begin
            w_sel_valid = i_req_valid[i];
            w_sel_last  = i_req_last[i];
            w_sel_data  = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_in_grant  = (r_state == ST_GRANT);
   // Reset suppresses the handshake so a beat presented on the reset edge is not written.
   assign w_accept_ok = w_in_grant & ~i_fifo_full & ~i_rst;

   always_comb begin
      o_req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant_id == ID_WIDTH'(i)) begin
            o_req_ready[i] = w_accept_ok;
         end
      end
   end

   assign o_fifo_wr_en   = w_accept_ok & w_sel_valid;
   assign o_fifo_wr_data = w_in_grant ? w_sel_data : '0;

   assign w_burst_end = ((r_beat_cnt + CNT_WIDTH'(1)) == CNT_WIDTH'(MAX_BURST));
   assign w_release   = o_fifo_wr_en & (w_sel_last | w_burst_end);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_grant_id <= ID_WIDTH'(NUM_REQ - 1);
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_enable && w_win_valid) begin
                  r_grant_id <= w_win_id;
                  r_beat_cnt <= '0;
                  r_state    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (o_fifo_wr_en) begin
                  r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
               end
               if (w_release) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_grant_valid = w_in_grant;
   assign o_grant_id    = r_grant_id;
   assign o_beat_cnt    = r_beat_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: queue-backed requesters, per-cycle checks
// at the falling edge and an ordered record of every word written to the FIFO.
module tb_fifo_wr_arbiter;

   localparam int DW = 16;
   localparam int NR = 4;
   localparam int MB = 8;
   localparam int IW = 2;
   localparam int CW = 4;

   logic             clk;
   logic             i_rst;
   logic             i_enable;
   logic [NR-1:0]    i_req_valid;
   logic [NR-1:0]    i_req_last;
   logic [NR*DW-1:0] i_req_data;
   logic [NR-1:0]    o_req_ready;
   logic [DW-1:0]    o_fifo_wr_data;
   logic             o_fifo_wr_en;
   logic             i_fifo_full;
   logic             o_grant_valid;
   logic [IW-1:0]    o_grant_id;
   logic [CW-1:0]    o_beat_cnt;

   fifo_wr_arbiter #(
      .DATA_WIDTH (DW),
      .NUM_REQ    (NR),
      .MAX_BURST  (MB)
   ) dut (
      .i_clk          (clk),
      .i_rst          (i_rst),
      .i_enable       (i_enable),
      .i_req_valid    (i_req_valid),
      .i_req_last     (i_req_last),
      .i_req_data     (i_req_data),
      .o_req_ready    (o_req_ready),
      .o_fifo_wr_data (o_fifo_wr_data),
      .o_fifo_wr_en   (o_fifo_wr_en),
      .i_fifo_full    (i_fifo_full),
      .o_grant_valid  (o_grant_valid),
      .o_grant_id     (o_grant_id),
      .o_beat_cnt     (o_beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] src_d [NR][$];
   bit            src_l [NR][$];
   bit   [NR-1:0] hold;
   bit   [NR-1:0] pop;
   logic [DW-1:0] got   [$];
   logic [DW-1:0] exp_q [$];
   bit            nx_rst, nx_enable, nx_full;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int r, input int p, input int b);
      return DW'((r << 12) | (p << 8) | b);
   endfunction

   task automatic load_pkt(input int r, input int p, input int n);
      for (int b = 0; b < n; b++) begin
         src_d[r].push_back(mk(r, p, b));
         src_l[r].push_back(b == n - 1);
      end
   endtask

   task automatic exp_add(input int r, input int p, input int b0, input int b1);
      for (int b = b0; b <= b1; b++) exp_q.push_back(mk(r, p, b));
   endtask

   function automatic bit all_empty();
      bit e;
      e = 1'b1;
      for (int i = 0; i < NR; i++) if (src_d[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   // One clock: retire accepted beats, apply next inputs, then sample at the falling edge.
   task automatic step();
      logic [NR-1:0]    v, l;
      logic [NR*DW-1:0] d;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (pop[i]) begin
            void'(src_d[i].pop_front());
            void'(src_l[i].pop_front());
         end
      end
      pop = '0;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < NR; i++) begin
         if (src_d[i].size() != 0 && !hold[i]) begin
            v[i]           = 1'b1;
            l[i]           = src_l[i][0];
            d[i*DW +: DW]  = src_d[i][0];
         end
      end
      i_rst       = nx_rst;
      i_enable    = nx_enable;
      i_fifo_full = nx_full;
      i_req_valid = v;
      i_req_last  = l;
      i_req_data  = d;
      @(negedge clk);
      for (int i = 0; i < NR; i++) pop[i] = o_req_ready[i] & i_req_valid[i];
      if (o_fifo_wr_en) got.push_back(o_fifo_wr_data);
      if (i_fifo_full) check("no_wr_on_full", 32'(o_fifo_wr_en), 32'd0);
   endtask

   task automatic drain(input string tag);
      bit done;
      done = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (all_empty() && !o_grant_valid) begin
            done = 1'b1;
            break;
         end
         step();
      end
      check({tag, "_drained"}, 32'(done), 32'd1);
   endtask

   task automatic cmp_got(input string tag);
      check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         check($sformatf("%s_word%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
      got.delete();
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst = 1'b1; i_enable = 1'b0; i_fifo_full = 1'b0;
      i_req_valid = '0; i_req_last = '0; i_req_data = '0;
      hold = '0; pop = '0;
      nx_rst = 1'b1; nx_enable = 1'b1; nx_full = 1'b0;

      // Reset
      step();
      check("rst_wr_en", 32'(o_fifo_wr_en), 32'd0);
      step();
      nx_rst = 1'b0;
      step();
      check("rst_gv",    32'(o_grant_valid), 32'd0);
      check("rst_gid",   32'(o_grant_id),    32'd3);
      check("rst_bcnt",  32'(o_beat_cnt),    32'd0);
      check("rst_ready", 32'(o_req_ready),   32'd0);
      check("rst_wr_en", 32'(o_fifo_wr_en),  32'd0);

      // Fairness: single-beat packets, grants 0,1,2,3,0 each after one IDLE cycle
      load_pkt(0, 0, 1); load_pkt(0, 1, 1);
      load_pkt(1, 0, 1); load_pkt(2, 0, 1); load_pkt(3, 0, 1);
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("fair_idle_gv%0d", k),    32'(o_grant_valid), 32'd0);
         check($sformatf("fair_idle_wr%0d", k),    32'(o_fifo_wr_en),  32'd0);
         step();
         check($sformatf("fair_gv%0d", k),   32'(o_grant_valid),  32'd1);
         check($sformatf("fair_gid%0d", k),  32'(o_grant_id),     32'(k % 4));
         check($sformatf("fair_wr%0d", k),   32'(o_fifo_wr_en),   32'd1);
         check($sformatf("fair_data%0d", k), 32'(o_fifo_wr_data), 32'(mk(k % 4, k / 4, 0)));
      end
      step();
      check("fair_end_gv", 32'(o_grant_valid), 32'd0);
      got.delete();

      // Packet lock: req3 first so req0 is next in rotation, then req0 5 beats vs req1
      load_pkt(3, 2, 1);
      drain("lock_pre");
      got.delete();
      load_pkt(0, 2, 5); load_pkt(1, 2, 2);
      step();
      check("lock_idle_gv", 32'(o_grant_valid), 32'd0);
      for (int b = 0; b < 5; b++) begin
         step();
         check($sformatf("lock_gid_b%0d", b),  32'(o_grant_id),     32'd0);
         check($sformatf("lock_wr_b%0d", b),   32'(o_fifo_wr_en),   32'd1);
         check($sformatf("lock_bcnt_b%0d", b), 32'(o_beat_cnt),     32'(b));
         check($sformatf("lock_data_b%0d", b), 32'(o_fifo_wr_data), 32'(mk(0, 2, b)));
      end
      step();
      check("lock_rel_gv",   32'(o_grant_valid), 32'd0);
      check("lock_rel_bcnt", 32'(o_beat_cnt),    32'd5);
      step();
      check("lock_next_gv",  32'(o_grant_valid), 32'd1);
      check("lock_next_gid", 32'(o_grant_id),    32'd1);
      drain("lock");
      exp_add(0, 2, 0, 4); exp_add(1, 2, 0, 1);
      cmp_got("lock");

      // Forced release: req2 12 beats is split 8 + 4 around req3's packet
      load_pkt(2, 3, 12); load_pkt(3, 3, 2);
      step();
      check("burst_idle_gv", 32'(o_grant_valid), 32'd0);
      for (int b = 0; b < 8; b++) begin
         step();
         check($sformatf("burst_wr_b%0d", b), 32'(o_fifo_wr_en), 32'd1);
      end
      step();
      check("burst_rel_gv",   32'(o_grant_valid), 32'd0);
      check("burst_rel_bcnt", 32'(o_beat_cnt),    32'd8);
      check("burst_rel_gid",  32'(o_grant_id),    32'd2);
      drain("burst");
      exp_add(2, 3, 0, 7); exp_add(3, 3, 0, 1); exp_add(2, 3, 8, 11);
      cmp_got("burst");

      // Backpressure and source stall mid-packet
      load_pkt(3, 4, 6);
      step(); step(); step();
      nx_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("bp_wr%0d", c),    32'(o_fifo_wr_en),  32'd0);
         check($sformatf("bp_ready%0d", c), 32'(o_req_ready),   32'd0);
         check($sformatf("bp_gv%0d", c),    32'(o_grant_valid), 32'd1);
         check($sformatf("bp_bcnt%0d", c),  32'(o_beat_cnt),    32'd2);
      end
      nx_full = 1'b0;
      hold[3] = 1'b1;
      step();
      check("stall_wr",    32'(o_fifo_wr_en),  32'd0);
      check("stall_gv",    32'(o_grant_valid), 32'd1);
      check("stall_ready", 32'(o_req_ready),   32'h8);
      hold[3] = 1'b0;
      drain("bp");
      check("bp_final_bcnt", 32'(o_beat_cnt), 32'd6);
      exp_add(3, 4, 0, 5);
      cmp_got("bp");

      // Enable gating: packet finishes, no new grant until enable returns
      load_pkt(1, 5, 4); load_pkt(2, 5, 1);
      step(); step();
      nx_enable = 1'b0;
      step(); step(); step();
      step();
      check("en_off_gv0", 32'(o_grant_valid), 32'd0);
      step();
      check("en_off_gv1", 32'(o_grant_valid), 32'd0);
      check("en_off_wr",  32'(o_fifo_wr_en),  32'd0);
      nx_enable = 1'b1;
      step();
      check("en_on_idle_gv", 32'(o_grant_valid), 32'd0);
      step();
      check("en_on_gv",   32'(o_grant_valid),  32'd1);
      check("en_on_gid",  32'(o_grant_id),     32'd2);
      check("en_on_data", 32'(o_fifo_wr_data), 32'(mk(2, 5, 0)));
      drain("en");
      exp_add(1, 5, 0, 3); exp_add(2, 5, 0, 0);
      cmp_got("en");

      // Reset on beat 3 of a 6-beat packet
      load_pkt(2, 6, 6);
      step(); step(); step();
      nx_rst = 1'b1;
      load_pkt(1, 6, 1);
      step();
      check("mrst_wr",    32'(o_fifo_wr_en), 32'd0);
      check("mrst_ready", 32'(o_req_ready),  32'd0);
      nx_rst = 1'b0;
      step();
      check("mrst_gv",   32'(o_grant_valid), 32'd0);
      check("mrst_gid",  32'(o_grant_id),    32'd3);
      check("mrst_bcnt", 32'(o_beat_cnt),    32'd0);
      step();
      check("mrst_next_gv",  32'(o_grant_valid), 32'd1);
      check("mrst_next_gid", 32'(o_grant_id),    32'd1);
      drain("mrst");
      exp_add(2, 6, 0, 1); exp_add(1, 6, 0, 0); exp_add(2, 6, 2, 5);
      cmp_got("mrst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one fifo_sync write port between NUM_REQ packet-oriented requesters.
- Locks the grant to one requester until that requester's packet ends (req_last) or MAX_BURST beats have been written, so packets stay contiguous.
- fifo_sync does not gate wr_en on full, so this block must never assert fifo_wr_en while fifo_full is high.
- Sits directly in front of the shared fifo_sync write side in the LCB datapath.

Parameters:
- DATA_WIDTH, 16: word width; must match the downstream fifo_sync.
- NUM_REQ, 4: number of requesters; must be 2 or more.
- MAX_BURST, 8: maximum beats per grant before forced release; must be 1 or more.
- ID_WIDTH, $clog2(NUM_REQ): width of the grant index.
- CNT_WIDTH, $clog2(MAX_BURST+1): width of the beat counter.

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  allows new grants; sampled only in IDLE.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_last  in  NUM_REQ  per-requester end-of-packet, qualified by req_valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept.
- fifo_wr_data  out  DATA_WIDTH  to fifo_sync wr_data.
- fifo_wr_en  out  1  to fifo_sync wr_en.
- fifo_full  in  1  from fifo_sync full.
- grant_valid  out  1  high while in GRANT.
- grant_id  out  ID_WIDTH  index of the current or most recent grantee.
- beat_cnt  out  CNT_WIDTH  beats written in the current grant.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. rst overrides every other input on that edge.
- Reset values: state=IDLE, grant_valid=0, grant_id=NUM_REQ-1 (so requester 0 has first priority), beat_cnt=0.
- Reset combinational consequences: req_ready=0 and fifo_wr_en=0.

State IDLE:
- req_ready = 0 and fifo_wr_en = 0.
- If enable=1 and |req_valid, pick the first i with req_valid[i]=1, searching from grant_id+1 upward with modulo-NUM_REQ wrap.
- Register the winner into grant_id, clear beat_cnt, move to GRANT.
- Arbitration latency: 1 cycle from valid to grant; the first transfer can occur in the following cycle.

State GRANT (g = grant_id):
- req_ready[g] = ~fifo_full; all other req_ready bits are 0.
- fifo_wr_en = req_valid[g] & ~fifo_full. This is combinational, with zero added latency.
- fifo_wr_data = req_data slice g, driven combinationally whenever in GRANT.
- Each accepted beat (fifo_wr_en=1) increments beat_cnt.
- Release to IDLE on an accepted beat with req_last[g]=1, or when the accepted beat makes beat_cnt+1 == MAX_BURST.
- After a forced release, the remainder of that packet competes again under round-robin.
- A stall (req_valid[g]=0 or fifo_full=1) holds GRANT indefinitely; no timeout.
- enable=0 during GRANT does not abort the packet. It only blocks the next grant.
- beat_cnt is cleared on entry to GRANT and holds its value in IDLE.

Boundary conditions:
- fifo_full=1 forces fifo_wr_en=0 in the same cycle, including on the cycle the FIFO just became full.
- A requester deasserting req_valid mid-packet is a stall, not a release.
- A single-beat packet (req_last on the first beat) lasts 1 cycle in GRANT, then returns to IDLE.
- Max throughput per grant is MAX_BURST beats per MAX_BURST+1 cycles.
- grant_id wraps from NUM_REQ-1 to 0 in the search. When NUM_REQ is not a power of two, index values at or above NUM_REQ never occur.
- rst asserted in GRANT: return to IDLE next edge and drop any partial packet; the beat presented on that cycle is not written.

Decomposition:
- Package fifo_arb_pkg holds the state enumeration (ST_IDLE, ST_GRANT) and a function next_rr(grant_id, req_valid) returning the winner index.
- One natural sub-module, rr_picker: combinational round-robin priority search, parameterised by NUM_REQ, with inputs req_valid and grant_id and outputs win_id and win_valid. The FSM and muxing stay in fifo_wr_arbiter.

Test Plan:
- Fairness after reset: rst released, all 4 req_valid high, every packet 1 beat -> grants in order 0,1,2,3,0; each fifo_wr_en pulse is preceded by 1 IDLE cycle.
- Packet lock: req0 sends a 5-beat packet (last on beat 5) while req1 is valid, MAX_BURST=8 -> 5 contiguous writes from req0, then req1 is granted; beat_cnt reads 5 on release.
- Forced release: req2 sends a 12-beat packet, MAX_BURST=8, req3 valid -> 8 beats of req2, then req3's packet, then req2 resumes at beat 9; no word is lost or duplicated.
- Backpressure: fifo_full high for 3 cycles mid-packet -> fifo_wr_en=0 and req_ready[g]=0 for exactly those cycles; the packet then resumes unchanged and the FIFO data order matches the source order.
- Enable gating: enable dropped during req1's 4-beat packet -> packet completes, then the block stays in IDLE with grant_valid=0; enable reasserted -> req2 is granted next.
- Reset mid-packet: rst pulsed on beat 3 of a 6-beat packet -> fifo_wr_en=0 on that edge, then state=IDLE, grant_id=NUM_REQ-1, and the next grant goes to the lowest valid index.
